// File: rtl/cas_player.sv
// ----------------------------------------------------------------------------
// cas_player
//   Cassette playback transmitter. Streams a .CAS image held in byte-addressed
//   storage as MSX FSK audio for the PSG port-A bit-7 tape input. CAS header
//   signatures are replaced by a silent gap plus a long or short 2400 Hz pilot;
//   every other byte is sent framed (start 0, d0..d7 LSB first, two stop 1s).
//   Playback timing advances only on ce_i and is frozen while motor_i=0.
//
// Ports
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   ce_i                 3.58 MHz clock enable; all wave/gap timing counts on it
//   play_i, stop_i       1-clk pulses: restart from offset 0 / abort to IDLE
//   motor_i              cassette motor; 0 freezes playback and silences audio
//   tape_size_i [24:0]   image length in bytes, sampled on play_i
//   rd_req_o, rd_addr_o  byte read request / offset
//   rd_ack_i, rd_data_i  read acknowledge pulse with data valid the same cycle
//   audio_o              FSK tape signal
//   busy_o, done_o       not IDLE/DONE, end of image reached
//
// Read handshake: rd_req_o rises with rd_addr_o already valid and both stay
//   stable until a cycle with rd_ack_i=1; that cycle transfers rd_data_i and
//   rd_req_o is low from the next cycle. One read is outstanding at a time and
//   rd_ack_i is ignored while rd_req_o=0.
//
// The FSM state is held in state_q (type state_t) so checkers can observe it.
// ----------------------------------------------------------------------------
module cas_player #(
   parameter int HALF_0        = 1491,
   parameter int HALF_1        = 746,
   parameter int LONG_HDR_CYC  = 4000,
   parameter int SHORT_HDR_CYC = 1000,
   parameter int GAP_TICKS     = 1789772
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        ce_i,
   input  logic        play_i,
   input  logic        stop_i,
   input  logic        motor_i,
   input  logic [24:0] tape_size_i,
   output logic        rd_req_o,
   output logic [24:0] rd_addr_o,
   input  logic        rd_ack_i,
   input  logic [7:0]  rd_data_i,
   output logic        audio_o,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CHECK, S_GAP, S_LOOK, S_TONE, S_SEND, S_DONE
   } state_t;

   localparam logic [10:0] H0_LAST    = 11'(HALF_0 - 1);
   localparam logic [10:0] H1_LAST    = 11'(HALF_1 - 1);
   localparam logic [12:0] LONG_LAST  = 13'(LONG_HDR_CYC - 1);
   localparam logic [12:0] SHORT_LAST = 13'(SHORT_HDR_CYC - 1);
   localparam logic [20:0] GAP_LAST   = 21'(GAP_TICKS - 1);
   // 1F A6 DE BA CC 13 7D 74 with the first byte in window slot 0
   localparam logic [63:0] CAS_SIG    = 64'h747D_13CC_BADE_A61F;

   state_t          state_q;
   logic [24:0]     ptr_q;
   logic [24:0]     size_q;
   logic [7:0][7:0] buf_q;
   logic [3:0]      n_q;         // bytes valid in the window
   logic [3:0]      fcnt_q;      // bytes fetched so far into the window
   logic [2:0]      idx_q;       // window byte being sent
   logic [3:0]      bit_idx_q;   // 0 start, 1..8 data, 9..10 stop
   logic [1:0]      phase_q;     // half-cycle within the current bit/pilot cycle
   logic [10:0]     half_cnt_q;
   logic [12:0]     pilot_cnt_q;
   logic [20:0]     gap_cnt_q;
   logic            long_q;

   logic [24:0] rem;
   logic [3:0]  n_fetch;
   logic [7:0]  cur_byte;
   logic [2:0]  dsel;
   logic        bit_val;
   logic [10:0] half_last;
   logic [1:0]  phase_last;
   logic [12:0] pilot_last;
   logic        half_end;
   logic        unit_end;
   logic [24:0] ptr_after_send;
   logic        long_byte;

   assign rem            = size_q - ptr_q;
   assign n_fetch        = (rem >= 25'd8) ? 4'd8 : rem[3:0];
   assign cur_byte       = buf_q[idx_q];
   assign dsel           = 3'(bit_idx_q - 4'd1);
   assign ptr_after_send = ptr_q + {21'd0, n_q};
   assign long_byte      = (rd_data_i == 8'hD0) || (rd_data_i == 8'hD3) || (rd_data_i == 8'hEA);

   always_comb begin
      bit_val = 1'b1;
      if (bit_idx_q == 4'd0)
         bit_val = 1'b0;
      else if (bit_idx_q <= 4'd8)
         bit_val = cur_byte[dsel];
   end

   // A "0" bit is one long cycle (2 halves of HALF_0); a "1" bit and a pilot
   // cycle use HALF_1 halves, four per "1" bit and two per pilot cycle.
   assign half_last  = (state_q == S_SEND && !bit_val) ? H0_LAST : H1_LAST;
   assign phase_last = (state_q == S_SEND && bit_val) ? 2'd3 : 2'd1;
   assign pilot_last = long_q ? LONG_LAST : SHORT_LAST;
   assign half_end   = (half_cnt_q == half_last);
   assign unit_end   = half_end && (phase_q == phase_last);

   assign busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o = (state_q == S_DONE);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         size_q      <= '0;
         buf_q       <= '0;
         n_q         <= '0;
         fcnt_q      <= '0;
         idx_q       <= '0;
         bit_idx_q   <= '0;
         phase_q     <= '0;
         half_cnt_q  <= '0;
         pilot_cnt_q <= '0;
         gap_cnt_q   <= '0;
         long_q      <= 1'b0;
         rd_req_o    <= 1'b0;
         rd_addr_o   <= '0;
         audio_o     <= 1'b0;
      end else if (stop_i || play_i) begin
         // stop_i has priority; play_i restarts from offset 0 in any state
         state_q     <= stop_i ? S_IDLE :
                        (tape_size_i == 25'd0) ? S_DONE : S_FETCH;
         ptr_q       <= '0;
         if (!stop_i)
            size_q   <= tape_size_i;
         fcnt_q      <= '0;
         idx_q       <= '0;
         bit_idx_q   <= '0;
         phase_q     <= '0;
         half_cnt_q  <= '0;
         pilot_cnt_q <= '0;
         gap_cnt_q   <= '0;
         rd_req_o    <= 1'b0;
         audio_o     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: audio_o <= 1'b0;

            S_FETCH: begin
               audio_o <= 1'b0;
               if (!rd_req_o) begin
                  if (fcnt_q == n_fetch) begin
                     n_q     <= n_fetch;
                     state_q <= S_CHECK;
                  end else begin
                     rd_req_o  <= 1'b1;
                     rd_addr_o <= ptr_q + {21'd0, fcnt_q};
                  end
               end else if (rd_ack_i) begin
                  buf_q[fcnt_q[2:0]] <= rd_data_i;
                  fcnt_q             <= fcnt_q + 4'd1;
                  rd_req_o           <= 1'b0;
               end
            end

            S_CHECK: begin
               audio_o <= 1'b0;
               if (n_q == 4'd8 && buf_q == CAS_SIG) begin
                  ptr_q     <= ptr_q + 25'd8;
                  gap_cnt_q <= '0;
                  state_q   <= S_GAP;
               end else begin
                  idx_q      <= '0;
                  bit_idx_q  <= '0;
                  phase_q    <= '0;
                  half_cnt_q <= '0;
                  state_q    <= S_SEND;
               end
            end

            S_GAP: begin
               if (ce_i) begin
                  audio_o <= 1'b0;
                  if (motor_i) begin
                     if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_LOOK;
                     end else begin
                        gap_cnt_q <= gap_cnt_q + 21'd1;
                     end
                  end
               end
            end

            // Peek at the byte after the header to pick the pilot length;
            // the byte is not consumed, the next FETCH reads it again.
            S_LOOK: begin
               audio_o <= 1'b0;
               if (ptr_q >= size_q) begin
                  long_q  <= 1'b0;
                  state_q <= S_TONE;
               end else if (!rd_req_o) begin
                  rd_req_o  <= 1'b1;
                  rd_addr_o <= ptr_q;
               end else if (rd_ack_i) begin
                  rd_req_o <= 1'b0;
                  long_q   <= long_byte;
                  state_q  <= S_TONE;
               end
            end

            S_TONE, S_SEND: begin
               if (ce_i) begin
                  if (!motor_i) begin
                     audio_o <= 1'b0;
                  end else begin
                     // even halves are high: every wave cycle starts high
                     audio_o <= ~phase_q[0];
                     if (!half_end) begin
                        half_cnt_q <= half_cnt_q + 11'd1;
                     end else begin
                        half_cnt_q <= '0;
                        if (!unit_end) begin
                           phase_q <= phase_q + 2'd1;
                        end else begin
                           phase_q <= '0;
                           if (state_q == S_TONE) begin
                              if (pilot_cnt_q == pilot_last) begin
                                 pilot_cnt_q <= '0;
                                 fcnt_q      <= '0;
                                 state_q     <= (ptr_q >= size_q) ? S_DONE : S_FETCH;
                              end else begin
                                 pilot_cnt_q <= pilot_cnt_q + 13'd1;
                              end
                           end else if (bit_idx_q != 4'd10) begin
                              bit_idx_q <= bit_idx_q + 4'd1;
                           end else begin
                              bit_idx_q <= '0;
                              if ({1'b0, idx_q} != n_q - 4'd1) begin
                                 idx_q <= idx_q + 3'd1;
                              end else begin
                                 idx_q   <= '0;
                                 ptr_q   <= ptr_after_send;
                                 fcnt_q  <= '0;
                                 state_q <= (ptr_after_send >= size_q) ? S_DONE : S_FETCH;
                              end
                           end
                        end
                     end
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cas_player.sv
// Bench for cas_player with shortened timing parameters. The expected audio is
// built from the image as a list of (level, length) runs measured in ce ticks
// taken with motor on; low runs at window/segment boundaries may be stretched
// by storage-read time and are accepted within a per-test slack.
module tb_cas_player;

   localparam int HALF_0        = 6;
   localparam int HALF_1        = 3;
   localparam int LONG_HDR_CYC  = 8;
   localparam int SHORT_HDR_CYC = 4;
   localparam int GAP_TICKS     = 50;
   localparam logic [7:0] SIG [8] = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};

   logic        clk_i;
   logic        reset_n_i;
   logic        ce_i;
   logic        play_i;
   logic        stop_i;
   logic        motor_i;
   logic [24:0] tape_size_i;
   logic        rd_req_o;
   logic [24:0] rd_addr_o;
   logic        rd_ack_i;
   logic [7:0]  rd_data_i;
   logic        audio_o;
   logic        busy_o;
   logic        done_o;

   cas_player #(
      .HALF_0(HALF_0), .HALF_1(HALF_1), .LONG_HDR_CYC(LONG_HDR_CYC),
      .SHORT_HDR_CYC(SHORT_HDR_CYC), .GAP_TICKS(GAP_TICKS)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .ce_i(ce_i), .play_i(play_i),
      .stop_i(stop_i), .motor_i(motor_i), .tape_size_i(tape_size_i),
      .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_ack_i(rd_ack_i),
      .rd_data_i(rd_data_i), .audio_o(audio_o), .busy_o(busy_o), .done_o(done_o)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [256];
   logic [31:0] exp_q[$];        // {flex, level, length[29:0]}
   int          exp_hi;
   int          slack;
   bit          mon_en = 0;
   bit          ack_rand = 0;
   int          wait_cnt = 0;
   bit          cur_lvl;
   int          cur_len;
   int          hi_runs;

   // ---------------- clock / reset ----------------
   initial begin
      clk_i = 0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      ce_i = 0;
      forever begin
         @(negedge clk_i);
         ce_i = ~ce_i;
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input bit ok, input longint act, input longint expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic void push_run(input bit lvl, input int len, input bit flex);
      logic [31:0] last;
      if (exp_q.size() > 0 && exp_q[exp_q.size()-1][30] == lvl) begin
         last = exp_q.pop_back();
         last[29:0] = last[29:0] + 30'(len);
         last[31] = last[31] | flex;
         exp_q.push_back(last);
      end else begin
         exp_q.push_back({flex, lvl, 30'(len)});
         if (lvl) exp_hi++;
      end
   endfunction

   function automatic void send_bit(input bit b);
      if (b) begin
         for (int k = 0; k < 2; k++) begin
            push_run(1'b1, HALF_1, 1'b0);
            push_run(1'b0, HALF_1, 1'b0);
         end
      end else begin
         push_run(1'b1, HALF_0, 1'b0);
         push_run(1'b0, HALF_0, 1'b0);
      end
   endfunction

   function automatic void send_byte(input logic [7:0] v);
      send_bit(1'b0);
      for (int k = 0; k < 8; k++) send_bit(v[k]);
      send_bit(1'b1);
      send_bit(1'b1);
   endfunction

   // Expected run list for an image of 'size' bytes in mem.
   function automatic void build_model(input int size);
      int ptr;
      int n;
      bit hdr;
      bit lng;
      exp_q.delete();
      exp_hi = 0;
      ptr = 0;
      push_run(1'b0, 0, 1'b1);
      while (ptr < size) begin
         n = (size - ptr >= 8) ? 8 : size - ptr;
         hdr = (n == 8);
         for (int k = 0; k < 8; k++)
            if (hdr && mem[ptr + k] != SIG[k]) hdr = 0;
         if (hdr) begin
            ptr += 8;
            push_run(1'b0, GAP_TICKS, 1'b0);
            push_run(1'b0, 0, 1'b1);
            lng = (ptr < size) && (mem[ptr] == 8'hD0 || mem[ptr] == 8'hD3 || mem[ptr] == 8'hEA);
            for (int c = 0; c < (lng ? LONG_HDR_CYC : SHORT_HDR_CYC); c++) begin
               push_run(1'b1, HALF_1, 1'b0);
               push_run(1'b0, HALF_1, 1'b0);
            end
         end else begin
            for (int k = 0; k < n; k++) send_byte(mem[ptr + k]);
            ptr += n;
         end
         push_run(1'b0, 0, 1'b1);
      end
   endfunction

   task automatic close_run();
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check("extra_run", 1'b0, cur_len, 0);
      end else begin
         e = exp_q.pop_front();
         check("run_level", cur_lvl == e[30], cur_lvl, e[30]);
         if (e[31])
            check("run_len_flex", cur_len >= int'(e[29:0]) && cur_len <= int'(e[29:0]) + slack,
                  cur_len, e[29:0]);
         else
            check("run_len", cur_len == int'(e[29:0]), cur_len, e[29:0]);
      end
      if (cur_lvl) hi_runs++;
   endtask

   task automatic sample_tick(input bit a);
      if (a == cur_lvl) begin
         cur_len++;
      end else begin
         close_run();
         cur_lvl = a;
         cur_len = 1;
      end
   endtask

   // ---------------- storage responder ----------------
   initial begin
      rd_ack_i  = 0;
      rd_data_i = 0;
      forever begin
         @(negedge clk_i);
         if (rd_ack_i) begin
            rd_ack_i = 0;
         end else if (rd_req_o && reset_n_i) begin
            if (wait_cnt <= 0) begin
               rd_ack_i  = 1;
               rd_data_i = mem[rd_addr_o[7:0]];
               wait_cnt  = ack_rand ? int'($urandom_range(50, 0)) : 0;
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   initial begin
      bit          ce_b, mot_b, ack_b, ps_b, rst_b;
      bit          req_prev;
      logic [24:0] addr_prev;
      req_prev  = 0;
      addr_prev = '0;
      forever begin
         @(posedge clk_i);
         ce_b  = ce_i;
         mot_b = motor_i;
         ack_b = rd_ack_i;
         ps_b  = play_i | stop_i;
         rst_b = reset_n_i;
         #1;
         if (rst_b && reset_n_i) begin
            if (req_prev && !ack_b && !ps_b) begin
               check("req_held", rd_req_o == 1'b1, rd_req_o, 1);
               check("addr_stable", rd_addr_o == addr_prev, rd_addr_o, addr_prev);
            end
            if (req_prev && ack_b && !ps_b)
               check("req_drop", rd_req_o == 1'b0, rd_req_o, 0);
            if (mon_en && ce_b) begin
               if (!mot_b) check("audio_motor_off", audio_o == 1'b0, audio_o, 0);
               else sample_tick(audio_o);
            end
         end
         req_prev  = rd_req_o;
         addr_prev = rd_addr_o;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic put_sig(input int base);
      for (int k = 0; k < 8; k++) mem[base + k] = SIG[k];
   endtask

   task automatic pulse_play(input int size);
      @(negedge clk_i);
      tape_size_i = 25'(size);
      play_i = 1;
      @(negedge clk_i);
      play_i = 0;
   endtask

   // hi_exp < 0 takes the high-run count from the model
   task automatic run_image(input int size, input int slack_ticks, input bit rand_ack,
                            input int hi_exp, input int limit);
      int n;
      build_model(size);
      slack    = slack_ticks;
      ack_rand = rand_ack;
      cur_lvl  = 0;
      cur_len  = 0;
      hi_runs  = 0;
      if (hi_exp < 0) hi_exp = exp_hi;
      @(negedge clk_i);
      tape_size_i = 25'(size);
      play_i = 1;
      mon_en = 1;
      @(negedge clk_i);
      play_i = 0;
      check("busy_after_play", busy_o == 1'b1 && done_o == 1'b0, busy_o, 1);
      n = 0;
      while (!done_o && n < limit) begin
         @(negedge clk_i);
         n++;
      end
      check("done_reached", done_o == 1'b1, done_o, 1);
      mon_en = 0;
      close_run();
      check("runs_drained", exp_q.size() == 0, exp_q.size(), 0);
      check("hi_runs", hi_runs == hi_exp, hi_runs, hi_exp);
      check("busy_in_done", busy_o == 1'b0, busy_o, 0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      reset_n_i   = 0;
      play_i      = 0;
      stop_i      = 0;
      motor_i     = 1;
      tape_size_i = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      #12;
      check("rst_req", rd_req_o == 1'b0, rd_req_o, 0);
      check("rst_addr", rd_addr_o == 25'd0, rd_addr_o, 0);
      check("rst_audio", audio_o == 1'b0, audio_o, 0);
      check("rst_busy", busy_o == 1'b0, busy_o, 0);
      check("rst_done", done_o == 1'b0, done_o, 0);
      @(negedge clk_i);
      reset_n_i = 1;
      repeat (2) @(negedge clk_i);

      // header + D3 00: long pilot then two framed bytes (8+18+13 high runs)
      put_sig(0);
      mem[8] = 8'hD3;
      mem[9] = 8'h00;
      run_image(10, 20, 0, 39, 3000);

      // header + 55: short pilot then 0,1,0,1,0,1,0,1,0,1,1 (4+17 high runs)
      mem[8] = 8'h55;
      run_image(9, 20, 0, 21, 3000);

      // partial signature 1F A6 DE sent as data, no gap (18+17+19 high runs)
      mem[0] = 8'h1F; mem[1] = 8'hA6; mem[2] = 8'hDE;
      run_image(3, 20, 0, 54, 3000);

      // play again mid-stream restarts from offset 0
      pulse_play(3);
      repeat (40) @(negedge clk_i);
      run_image(3, 20, 0, 54, 3000);

      // motor dropped for 10000 ce during the start bit of A5 (17+17 high runs)
      mem[0] = 8'hA5; mem[1] = 8'h3C;
      fork
         run_image(2, 20, 0, 34, 25000);
         begin
            int k;
            k = 0;
            while (!audio_o && k < 2000) begin
               @(negedge clk_i);
               k++;
            end
            repeat (4) @(negedge clk_i);
            motor_i = 0;
            repeat (20000) @(negedge clk_i);
            motor_i = 1;
         end
      join

      // data window, header, EA (long pilot), 01; fixed then random ack latency
      for (int i = 0; i < 8; i++) mem[i] = 8'(i * 29 + 3);
      put_sig(8);
      mem[16] = 8'hEA;
      mem[17] = 8'h01;
      run_image(18, 20, 0, -1, 4000);
      run_image(18, 300, 1, -1, 12000);
      ack_rand = 0;

      // async reset in the middle of sending
      put_sig(0);
      mem[8] = 8'hD3;
      mem[9] = 8'h00;
      pulse_play(10);
      repeat (300) @(negedge clk_i);
      check("mid_busy", busy_o == 1'b1, busy_o, 1);
      reset_n_i = 0;
      #1;
      check("mid_rst_req", rd_req_o == 1'b0, rd_req_o, 0);
      check("mid_rst_addr", rd_addr_o == 25'd0, rd_addr_o, 0);
      check("mid_rst_audio", audio_o == 1'b0, audio_o, 0);
      check("mid_rst_busy", busy_o == 1'b0, busy_o, 0);
      check("mid_rst_done", done_o == 1'b0, done_o, 0);
      @(negedge clk_i);
      reset_n_i = 1;
      wait_cnt = 0;
      repeat (2) @(negedge clk_i);

      // empty image goes straight to DONE on the next clock
      pulse_play(0);
      check("empty_done", done_o == 1'b1, done_o, 1);
      check("empty_busy", busy_o == 1'b0, busy_o, 0);
      // stop returns to IDLE
      stop_i = 1;
      @(negedge clk_i);
      stop_i = 0;
      check("stop_done", done_o == 1'b0, done_o, 0);
      // stop beats a simultaneous play
      tape_size_i = 25'd5;
      play_i = 1;
      stop_i = 1;
      @(negedge clk_i);
      play_i = 0;
      stop_i = 0;
      check("stop_wins_busy", busy_o == 1'b0, busy_o, 0);
      @(negedge clk_i);
      check("stop_wins_req", rd_req_o == 1'b0, rd_req_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
